// File: rtl/uart_program_loader_if.sv
// uart_program_loader_if: receiver-side and instruction-memory-side signals of
// the UART program loader, bundled so the loader and its environment share one
// port list.
//
// Memory write handshake: mem_wr_en is "valid", mem_ready is "ready"; a word
// transfers in every cycle where both are high. While mem_wr_en is high,
// mem_addr and mem_wdata are held stable. mem_ready may be asserted at any time.
// The receiver side has no back-pressure: rx_data_ready is a one-cycle strobe.
interface uart_program_loader_if #(
   parameter int ADDR_WIDTH = 16,
   parameter int WORD_BYTES = 4
);
   logic [7:0]              rx_data;
   logic                    rx_data_ready;
   logic                    rx_parity_error;
   logic                    rx_enable;
   logic                    mem_wr_en;
   logic                    mem_ready;
   logic [ADDR_WIDTH-1:0]   mem_addr;
   logic [8*WORD_BYTES-1:0] mem_wdata;

   // Loader side: consumes receiver bytes, drives memory writes.
   modport master (
      input  rx_data, rx_data_ready, rx_parity_error, mem_ready,
      output rx_enable, mem_wr_en, mem_addr, mem_wdata
   );

   // Environment side: UART receiver and instruction memory.
   modport slave (
      output rx_data, rx_data_ready, rx_parity_error, mem_ready,
      input  rx_enable, mem_wr_en, mem_addr, mem_wdata
   );
endinterface

// File: rtl/uart_program_loader.sv
// uart_program_loader: turns the UART receiver byte stream into program words
// and writes them into CPU instruction memory, holding the CPU in halt while a
// frame is loading.
// Frame: 0xA5, LEN_LO, LEN_HI, LEN*WORD_BYTES payload bytes (little-endian
// within a word), then an XOR checksum over the length and payload bytes.
// Optional macro UART_LOADER_ACK_EN adds an ACK (0x06) / NAK (0x15) response
// interface towards a UART transmitter.
module uart_program_loader #(
   parameter int unsigned WORD_BYTES     = 4,
   parameter int unsigned ADDR_WIDTH     = 16,
   parameter int unsigned MAX_WORDS      = 4096,
   parameter int unsigned TIMEOUT_CYCLES = 100000
) (
   input  logic                  clk,
   input  logic                  Rst,
   uart_program_loader_if.master bus,
   output logic                  cpu_halt,
   output logic                  load_done,
   output logic                  load_error,
   output logic [2:0]            error_code,
   output logic [ADDR_WIDTH:0]   words_written,
`ifdef UART_LOADER_ACK_EN
   output logic [7:0]            tx_data,
   output logic                  tx_start,
   input  logic                  tx_busy,
`endif
   output logic [2:0]            state_dbg
);

   localparam int WORD_W = 8 * WORD_BYTES;
   localparam int BC_W   = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

   localparam logic [2:0] ERR_NONE     = 3'd0;
   localparam logic [2:0] ERR_PARITY   = 3'd1;
   localparam logic [2:0] ERR_LENGTH   = 3'd2;
   localparam logic [2:0] ERR_CHECKSUM = 3'd3;
   localparam logic [2:0] ERR_TIMEOUT  = 3'd4;
   localparam logic [2:0] ERR_OVERRUN  = 3'd5;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LEN_LO = 3'd1,
      S_LEN_HI = 3'd2,
      S_DATA   = 3'd3,
      S_CHECK  = 3'd4,
      S_FLUSH  = 3'd5,
      S_ERROR  = 3'd6
   } state_t;

   state_t            state, state_n;
   logic [15:0]       len;
   logic [7:0]        checksum;
   logic [BC_W-1:0]   byte_cnt;
   logic [15:0]       word_cnt;
   logic [WORD_W-1:0] asm_word;
   logic [31:0]       tmo_cnt;

   logic              byte_ok, is_sync, timed, tmo_hit, word_fin, last_word;
   logic              accept, overrun;
   logic [15:0]       len_full;
   logic [WORD_W-1:0] asm_n;
   logic              err_set, start_frame, cap_lo, cap_hi, data_byte, finish;
   logic [2:0]        err_code_n;

   assign state_dbg     = state;
   assign bus.rx_enable = 1'b1;

   assign byte_ok   = bus.rx_data_ready && !bus.rx_parity_error;
   assign is_sync   = byte_ok && (bus.rx_data == 8'hA5);
   assign timed     = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                      (state == S_DATA)   || (state == S_CHECK);
   // A byte in the terminal cycle clears the counter instead of timing out.
   assign tmo_hit   = timed && !bus.rx_data_ready && (tmo_cnt == TIMEOUT_CYCLES - 1);
   assign word_fin  = (state == S_DATA) && byte_ok && (byte_cnt == BC_W'(WORD_BYTES - 1));
   assign last_word = (word_cnt + 16'd1) == len;
   assign accept    = bus.mem_wr_en && bus.mem_ready;
   // A write accepted in the completing cycle frees the slot, so it is not an overrun.
   assign overrun   = word_fin && bus.mem_wr_en && !bus.mem_ready;
   assign len_full  = {bus.rx_data, len[7:0]};
   // New byte enters at the top; after WORD_BYTES shifts byte 0 sits in [7:0].
   assign asm_n     = (asm_word >> 8) | (WORD_W'(bus.rx_data) << (WORD_W - 8));

   // State register.
   always_ff @(posedge clk) begin
      if (Rst) state <= S_IDLE;
      else     state <= state_n;
   end

   // Next-state decode with error priority parity > overrun > timeout > normal.
   always_comb begin
      state_n     = state;
      err_set     = 1'b0;
      err_code_n  = ERR_NONE;
      start_frame = 1'b0;
      cap_lo      = 1'b0;
      cap_hi      = 1'b0;
      data_byte   = 1'b0;
      finish      = 1'b0;
      if (bus.rx_data_ready && bus.rx_parity_error && (state != S_IDLE)) begin
         state_n    = S_ERROR;
         err_set    = 1'b1;
         err_code_n = ERR_PARITY;
      end else if (overrun) begin
         state_n    = S_ERROR;
         err_set    = 1'b1;
         err_code_n = ERR_OVERRUN;
      end else if (tmo_hit) begin
         state_n    = S_ERROR;
         err_set    = 1'b1;
         err_code_n = ERR_TIMEOUT;
      end else begin
         case (state)
            S_IDLE, S_ERROR: begin
               if (is_sync) begin
                  state_n     = S_LEN_LO;
                  start_frame = 1'b1;
               end
            end
            S_LEN_LO: begin
               if (byte_ok) begin
                  state_n = S_LEN_HI;
                  cap_lo  = 1'b1;
               end
            end
            S_LEN_HI: begin
               if (byte_ok) begin
                  cap_hi = 1'b1;
                  if ({16'd0, len_full} > MAX_WORDS) begin
                     state_n    = S_ERROR;
                     err_set    = 1'b1;
                     err_code_n = ERR_LENGTH;
                  end else if (len_full == 16'd0) begin
                     state_n = S_CHECK;
                  end else begin
                     state_n = S_DATA;
                  end
               end
            end
            S_DATA: begin
               if (byte_ok) begin
                  data_byte = 1'b1;
                  if (word_fin && last_word) state_n = S_CHECK;
               end
            end
            S_CHECK: begin
               if (byte_ok) begin
                  if (bus.rx_data != checksum) begin
                     state_n    = S_ERROR;
                     err_set    = 1'b1;
                     err_code_n = ERR_CHECKSUM;
                  end else begin
                     state_n = S_FLUSH;
                  end
               end
            end
            S_FLUSH: begin
               if (!bus.mem_wr_en) begin
                  state_n = S_IDLE;
                  finish  = 1'b1;
               end
            end
            default: state_n = S_IDLE;
         endcase
      end
   end

   // Datapath: length capture, checksum, word assembly, memory write and status.
   always_ff @(posedge clk) begin
      if (Rst) begin
         len           <= '0;
         checksum      <= '0;
         byte_cnt      <= '0;
         word_cnt      <= '0;
         asm_word      <= '0;
         tmo_cnt       <= '0;
         bus.mem_wr_en <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
         cpu_halt      <= 1'b0;
         load_done     <= 1'b0;
         load_error    <= 1'b0;
         error_code    <= ERR_NONE;
         words_written <= '0;
      end else begin
         load_done <= 1'b0;
         if (accept) begin
            bus.mem_wr_en <= 1'b0;
            bus.mem_addr  <= bus.mem_addr + 1'b1;
            words_written <= words_written + 1'b1;
         end
         if (start_frame) begin
            cpu_halt      <= 1'b1;
            words_written <= '0;
            checksum      <= '0;
            bus.mem_addr  <= '0;
            load_error    <= 1'b0;
            error_code    <= ERR_NONE;
            byte_cnt      <= '0;
            word_cnt      <= '0;
         end
         if (cap_lo) begin
            len[7:0] <= bus.rx_data;
            checksum <= checksum ^ bus.rx_data;
         end
         if (cap_hi) begin
            len[15:8] <= bus.rx_data;
            checksum  <= checksum ^ bus.rx_data;
         end
         if (data_byte) begin
            checksum <= checksum ^ bus.rx_data;
            asm_word <= asm_n;
            if (word_fin) begin
               byte_cnt      <= '0;
               word_cnt      <= word_cnt + 16'd1;
               bus.mem_wdata <= asm_n;
               bus.mem_wr_en <= 1'b1;
            end else begin
               byte_cnt <= byte_cnt + 1'b1;
            end
         end
         if (finish) begin
            load_done <= 1'b1;
            cpu_halt  <= 1'b0;
         end
         if (err_set) begin
            load_error    <= 1'b1;
            error_code    <= err_code_n;
            bus.mem_wr_en <= 1'b0;
         end
         if (bus.rx_data_ready || !timed) tmo_cnt <= '0;
         else                             tmo_cnt <= tmo_cnt + 32'd1;
      end
   end

`ifdef UART_LOADER_ACK_EN
   logic       tx_pend;
   logic [7:0] tx_pend_data;

   // Hold one ACK/NAK response (newest wins) and launch it once the transmitter is free.
   always_ff @(posedge clk) begin
      if (Rst) begin
         tx_pend      <= 1'b0;
         tx_pend_data <= 8'h00;
         tx_start     <= 1'b0;
         tx_data      <= 8'h00;
      end else begin
         tx_start <= 1'b0;
         if (tx_pend && !tx_busy) begin
            tx_start <= 1'b1;
            tx_data  <= tx_pend_data;
            tx_pend  <= 1'b0;
         end
         if ((state == S_FLUSH) && (state_n == S_IDLE)) begin
            tx_pend      <= 1'b1;
            tx_pend_data <= 8'h06;
         end else if ((state != S_ERROR) && (state_n == S_ERROR)) begin
            tx_pend      <= 1'b1;
            tx_pend_data <= 8'h15;
         end
      end
   end
`endif

endmodule

// File: tb/tb_uart_program_loader.sv
// tb_uart_program_loader: self-checking bench for uart_program_loader.
// Frames are built from the frame rules (sync, length, payload, XOR checksum);
// expected memory writes come from a byte-array model and sit in exp_q.
module tb_uart_program_loader;

   localparam int WB   = 4;
   localparam int AW   = 16;
   localparam int DW   = 8 * WB;
   localparam int MAXW = 8;
   localparam int TMO  = 40;

   logic            tb_clk = 1'b0;
   logic            Rst;
   logic            cpu_halt, load_done, load_error;
   logic [2:0]      error_code;
   logic [AW:0]     words_written;
   logic [2:0]      state_dbg;
`ifdef UART_LOADER_ACK_EN
   logic [7:0]      tx_data;
   logic            tx_start;
   logic            tx_busy = 1'b0;
   logic [7:0]      last_tx = 8'h00;
`endif

   uart_program_loader_if #(.ADDR_WIDTH(AW), .WORD_BYTES(WB)) bus ();

   uart_program_loader #(
      .WORD_BYTES(WB), .ADDR_WIDTH(AW), .MAX_WORDS(MAXW), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(tb_clk),
      .Rst(Rst),
      .bus(bus),
      .cpu_halt(cpu_halt),
      .load_done(load_done),
      .load_error(load_error),
      .error_code(error_code),
      .words_written(words_written),
`ifdef UART_LOADER_ACK_EN
      .tx_data(tx_data),
      .tx_start(tx_start),
      .tx_busy(tx_busy),
`endif
      .state_dbg(state_dbg)
   );

   // ---------------- clock / reset ----------------
   always #5 tb_clk = ~tb_clk;

   initial begin
      #500000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard ----------------
   int                 n_chk = 0;
   int                 n_err = 0;
   int                 done_cnt = 0;
   int                 mr_mode = 0;   // 0 ready, 1 stalled, 2 random with bounded stall
   int                 pend = 0;
   logic [AW+DW-1:0]   exp_q[$];
   logic [AW+DW-1:0]   exp_w;
   logic [7:0]         p[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Memory model: accepts per mr_mode; random mode never stalls a write beyond 3 cycles.
   always @(posedge tb_clk) begin
      #1;
      case (mr_mode)
         0:       bus.mem_ready = 1'b1;
         1:       bus.mem_ready = 1'b0;
         default: bus.mem_ready = (pend >= 2) || ($urandom_range(0, 3) != 0);
      endcase
   end

   // Monitor: every accepted write must match the next expected {addr, data}.
   always @(negedge tb_clk) begin
      if (bus.mem_wr_en && !bus.mem_ready) pend = pend + 1;
      else                                 pend = 0;
      if (Rst === 1'b0) begin
         if (bus.mem_wr_en && bus.mem_ready) begin
            if (exp_q.size() == 0) begin
               check("wr_extra", {1'b1, bus.mem_addr, bus.mem_wdata}, 64'd0);
            end else begin
               exp_w = exp_q.pop_front();
               check("wr", {bus.mem_addr, bus.mem_wdata}, exp_w);
            end
         end
         if (load_done) done_cnt++;
`ifdef UART_LOADER_ACK_EN
         if (tx_start) last_tx = tx_data;
`endif
      end
   end

   // ---------------- reference model ----------------
   task automatic expect_words(input logic [7:0] pay[$]);
      logic [DW-1:0] word;
      for (int w = 0; w < pay.size() / WB; w++) begin
         word = '0;
         for (int b = 0; b < WB; b++) word = word | (DW'(pay[w*WB + b]) << (8*b));
         exp_q.push_back({AW'(w), word});
      end
   endtask

   // ---------------- drivers ----------------
   task automatic idle(input int n);
      repeat (n) begin
         @(posedge tb_clk);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input bit par);
      bus.rx_data         = b;
      bus.rx_data_ready   = 1'b1;
      bus.rx_parity_error = par;
      @(posedge tb_clk);
      #1;
      bus.rx_data_ready   = 1'b0;
      bus.rx_parity_error = 1'b0;
   endtask

   task automatic send_head(input int len, input int max_gap);
      send_byte(8'hA5, 1'b0);
      check("halt_on_sync", cpu_halt, 1);
      idle($urandom_range(0, max_gap));
      send_byte(len[7:0], 1'b0);
      idle($urandom_range(0, max_gap));
      send_byte(len[15:8], 1'b0);
   endtask

   task automatic send_body(input int len, input logic [7:0] pay[$], input bit bad, input int max_gap);
      logic [7:0] cs;
      cs = len[7:0] ^ len[15:8];
      foreach (pay[i]) begin
         cs = cs ^ pay[i];
         send_byte(pay[i], 1'b0);
         idle($urandom_range(0, max_gap));
      end
      idle(4);
      send_byte(bad ? (cs ^ 8'h01) : cs, 1'b0);
   endtask

   task automatic wait_end(input string tag);
      for (int i = 0; i < 300; i++) begin
         if (load_done || load_error) break;
         idle(1);
      end
      check({tag, "_end"}, load_done | load_error, 1);
   endtask

   task automatic run_frame(input string tag, input int len, input logic [7:0] pay[$],
                            input bit bad, input int max_gap, input int pre_wait);
      int dc0;
      logic [2:0] ec;
      ec  = bad ? 3'd3 : 3'd0;
      dc0 = done_cnt;
      expect_words(pay);
      send_head(len, max_gap);
      idle(pre_wait);
      send_body(len, pay, bad, max_gap);
      wait_end(tag);
      check({tag, "_code"}, error_code, ec);
      check({tag, "_err"}, load_error, bad);
      check({tag, "_halt"}, cpu_halt, bad);
      check({tag, "_words"}, words_written, len);
      idle(2);
      check({tag, "_dones"}, done_cnt - dc0, bad ? 0 : 1);
      check({tag, "_q_empty"}, exp_q.size(), 0);
   endtask

   task automatic rand_payload(input int len);
      p.delete();
      for (int i = 0; i < len * WB; i++) p.push_back(8'($urandom_range(0, 255)));
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_rx_enable"}, bus.rx_enable, 1);
      check({tag, "_mem_wr_en"}, bus.mem_wr_en, 0);
      check({tag, "_mem_addr"}, bus.mem_addr, 0);
      check({tag, "_mem_wdata"}, bus.mem_wdata, 0);
      check({tag, "_cpu_halt"}, cpu_halt, 0);
      check({tag, "_load_done"}, load_done, 0);
      check({tag, "_load_error"}, load_error, 0);
      check({tag, "_error_code"}, error_code, 0);
      check({tag, "_words"}, words_written, 0);
   endtask

`ifdef UART_LOADER_ACK_EN
   task automatic ack_check(input string tag, input logic [7:0] exp);
      idle(4);
      check(tag, last_tx, exp);
   endtask
`endif

   // ---------------- stimulus ----------------
   initial begin
      bus.rx_data         = 8'h00;
      bus.rx_data_ready   = 1'b0;
      bus.rx_parity_error = 1'b0;
      Rst = 1'b1;
      idle(3);
      check_reset_vals("reset");
      Rst = 1'b0;
      idle(2);

      // Single word 0xDEADBEEF at address 0.
      p = {8'hEF, 8'hBE, 8'hAD, 8'hDE};
      run_frame("one_word", 1, p, 1'b0, 0, 0);
`ifdef UART_LOADER_ACK_EN
      ack_check("ack_ok", 8'h06);
`endif

      // Empty program, good and bad checksum.
      p.delete();
      run_frame("len0", 0, p, 1'b0, 1, 0);
      run_frame("len0_badsum", 0, p, 1'b1, 1, 0);
`ifdef UART_LOADER_ACK_EN
      ack_check("nak_sum", 8'h15);
`endif

      // Overrun: second word completes while the first is still stalled.
      mr_mode = 1;
      send_head(2, 0);
      rand_payload(2);
      foreach (p[i]) send_byte(p[i], 1'b0);
      idle(1);
      check("ovr_code", error_code, 5);
      check("ovr_err", load_error, 1);
      check("ovr_wr_en", bus.mem_wr_en, 0);
      check("ovr_halt", cpu_halt, 1);
      mr_mode = 0;
      idle(2);
      rand_payload(3);
      run_frame("after_ovr", 3, p, 1'b0, 2, 0);

      // Length boundary: MAX_WORDS+1 rejected, MAX_WORDS accepted.
      send_head(MAXW + 1, 0);
      check("len_big_code", error_code, 2);
      check("len_big_err", load_error, 1);
      rand_payload(MAXW);
      run_frame("len_max", MAXW, p, 1'b0, 1, 0);

      // Timeout exactly at terminal count after LEN_HI.
      send_head(1, 0);
      idle(TMO - 1);
      check("tmo_pre_err", load_error, 0);
      idle(1);
      check("tmo_code", error_code, 4);
      check("tmo_err", load_error, 1);

      // A byte landing on the terminal-count cycle keeps the frame alive.
      rand_payload(1);
      run_frame("tmo_edge", 1, p, 1'b0, 0, TMO - 1);

      // Parity error on a payload byte.
      send_head(1, 0);
      send_byte(8'hEF, 1'b0);
      send_byte(8'hBE, 1'b1);
      check("par_code", error_code, 1);
      check("par_err", load_error, 1);
      check("par_halt", cpu_halt, 1);

      // Reset in the middle of the payload.
      send_head(2, 0);
      send_byte(8'h11, 1'b0);
      send_byte(8'h22, 1'b0);
      Rst = 1'b1;
      idle(1);
      check_reset_vals("rst_mid");
      Rst = 1'b0;
      idle(2);

      // Randomized frames with random memory stalls and occasional bad checksum.
      mr_mode = 2;
      for (int f = 0; f < 8; f++) begin
         int len;
         bit bad;
         len = $urandom_range(1, MAXW);
         bad = ($urandom_range(0, 3) == 0);
         rand_payload(len);
         run_frame($sformatf("rnd%0d", f), len, p, bad, 3, 0);
      end
      mr_mode = 0;
      idle(4);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
